rr_mux_feeder: RTL
==================

# rr_mux_feeder

Two-channel round-robin feeder that sits directly upstream of the WIDTH-bit muxed D-input register. It accepts words from two independent valid/ready sources (A and B) and buffers one word per channel. Each cycle it grants at most one buffered word and drives the register's `d1`, `d2` and `data_select` inputs. It also produces a `q_valid` flag that is delayed by one cycle so it lines up with the register's `q_out`.

## Interface
- `WIDTH`, default 4: data width; must match the downstream register's WIDTH.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rstN`  input  1  asynchronous reset, active-low.
- `a_valid`  input  1  channel A offers `a_data`.
- `a_ready`  output  1  channel A buffer can accept this cycle.
- `a_data`  input  WIDTH  channel A word.
- `b_valid`  input  1  channel B offers `b_data`.
- `b_ready`  output  1  channel B buffer can accept this cycle.
- `b_data`  input  WIDTH  channel B word.
- `hold`  input  1  when 1, no grant is issued this cycle.
- `d1`  output  WIDTH  to register `d1`; carries channel A words.
- `d2`  output  WIDTH  to register `d2`; carries channel B words.
- `data_select`  output  1  to register `data_select`; 1 selects A (`d1`), 0 selects B (`d2`).
- `sel_valid`  output  1  `d1`/`d2`/`data_select` hold a newly granted word this cycle.
- `q_valid`  output  1  `sel_valid` delayed one cycle; qualifies the register's `q_out`.
- `grant_cnt`  output  8  free-running count of grants, wraps 255→0.

## Operation
- Each channel has a 1-entry buffer: a full flag plus a WIDTH-bit data register.
- Accept on channel X when `X_valid && X_ready` at a rising edge.
- `X_ready = !X_full || pop_X`. `pop_X` depends only on registered state and `hold`, so there is no valid→ready combinational path.
- Simultaneous pop and accept on the same channel: the buffer is refilled with the new word and stays full.
- Grant eligibility: channel full and `hold == 0`.
- Only one channel eligible: grant that channel.
- Both channels eligible: grant the channel that is not `last_grant`.
- `last_grant` is updated on every grant.
- After reset `last_grant = B`, so A wins the first tie.
- Grant to A at an edge: `d1` ← buffer A, `data_select` ← 1, `sel_valid` ← 1, `d2` unchanged.
- Grant to B at an edge: `d2` ← buffer B, `data_select` ← 0, `sel_valid` ← 1, `d1` unchanged.
- No grant at an edge: `d1`, `d2` and `data_select` hold their values; `sel_valid` ← 0.
- `q_valid` ← `sel_valid` on every edge.
- `grant_cnt` increments by 1 on each grant and uses modulo-256 arithmetic.
- Reset values (all asynchronous on `rstN` low):
  - `d1`, `d2`, `grant_cnt` = 0.
  - `data_select`, `sel_valid`, `q_valid` = 0.
  - Both buffers empty, `last_grant = B`.
  - As a result `a_ready` and `b_ready` are 1.
- Reset mid-operation: buffered words are discarded and no grant is issued while `rstN` is low.
- The first accept is possible at the first rising edge after `rstN` deasserts.

## Timing
- Edge n: word accepted into channel X.
- Edge n+1: earliest grant; `sel_valid` = 1 and selects/data are visible after edge n+1.
- Edge n+2: downstream register captures the word; `q_valid` = 1 with the matching `q_out` after edge n+2.
- Accept-to-`q_valid` latency is 2 cycles minimum, plus any cycles spent stalled by `hold` or by losing arbitration.
- Sustained throughput is 1 grant per cycle in aggregate.
- With both channels continuously valid, grants strictly alternate A, B, A, B, …, and each channel gets one grant every 2 cycles.
- A lone continuously valid channel is granted every cycle with `ready` held at 1 (back-to-back pop+accept).
- `hold` asserted at edge k: no grant at edge k, `sel_valid` = 0 after edge k, buffers retain their words, and `X_ready` = `!X_full`.
- `last_grant` does not change during `hold`.

## Test plan
- Reset, then A sends 0x3 at edge 1 → after edge 2: `d1`=0x3, `data_select`=1, `sel_valid`=1; after edge 3: `q_valid`=1 and `q_out`=0x3; `d2` stays 0.
- A and B both valid from edge 1 with sequences A=1,2,3 and B=9,A,B → `q_out` order is 1,9,2,A,3,B; `data_select` toggles 1,0,1,0,1,0; `grant_cnt`=6.
- B alone valid for 5 cycles with 0x0..0x4 → `b_ready` is 1 throughout; `q_out` is 0..4 on consecutive cycles; `data_select`=0; `d1` unchanged.
- Both buffers full and `hold`=1 for 3 cycles → `sel_valid`=0, `a_ready`=`b_ready`=0, outputs frozen; the first grant after release goes to the channel that is not `last_grant`.
- 256 grants from reset → `grant_cnt` wraps to 0 on the 256th grant.
- Drive `rstN` low while both buffers are full and `sel_valid`=1 → immediately all outputs are 0 and both readies are 1; after release, a new A word is the first one granted.

Source files
------------

// File: rtl/rr_mux_feeder.sv
// rr_mux_feeder: two-channel round-robin feeder for a muxed D-input register.
// Buffers one word per channel and grants at most one word per cycle.
//
// Ports:
//   clk, rstN            clock, async active-low reset
//   a_valid/a_ready/a_data  channel A valid/ready source
//   b_valid/b_ready/b_data  channel B valid/ready source
//   hold                 suppress grants this cycle
//   d1, d2, data_select  drive the downstream register inputs
//   sel_valid            d1/d2/data_select carry a freshly granted word
//   q_valid              sel_valid delayed to line up with register q_out
//   grant_cnt            modulo-256 grant counter
module rr_mux_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             hold,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic             data_select,
  output logic             sel_valid,
  output logic             q_valid,
  output logic [7:0]       grant_cnt
);

  logic             a_full;
  logic             b_full;
  logic [WIDTH-1:0] a_buf;
  logic [WIDTH-1:0] b_buf;
  logic             last_b;
  logic             pop_a;
  logic             pop_b;
  logic             acc_a;
  logic             acc_b;

  // Pops use only registered state and hold, so ready never
  // depends combinationally on valid.
  assign pop_a = a_full && !hold && (!b_full || last_b);
  assign pop_b = b_full && !hold && !pop_a;

  assign a_ready = !a_full || pop_a;
  assign b_ready = !b_full || pop_b;

  assign acc_a = a_valid && a_ready;
  assign acc_b = b_valid && b_ready;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_buf  <= '0;
      b_buf  <= '0;
    end else begin
      if (acc_a) begin
        a_full <= 1'b1;
        a_buf  <= a_data;
      end else if (pop_a) begin
        a_full <= 1'b0;
      end
      if (acc_b) begin
        b_full <= 1'b1;
        b_buf  <= b_data;
      end else if (pop_b) begin
        b_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      d1          <= '0;
      d2          <= '0;
      data_select <= 1'b0;
      sel_valid   <= 1'b0;
      q_valid     <= 1'b0;
      grant_cnt   <= 8'd0;
      last_b      <= 1'b1;
    end else begin
      q_valid <= sel_valid;
      unique case (1'b1)
        pop_a: begin
          d1          <= a_buf;
          data_select <= 1'b1;
          sel_valid   <= 1'b1;
          last_b      <= 1'b0;
          grant_cnt   <= grant_cnt + 8'd1;
        end
        pop_b: begin
          d2          <= b_buf;
          data_select <= 1'b0;
          sel_valid   <= 1'b1;
          last_b      <= 1'b1;
          grant_cnt   <= grant_cnt + 8'd1;
        end
        default: begin
          sel_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
